// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer generator and the tone period meter:
// meter FSM state encoding, default silence timeout, and the nominal clock rate.
package buzz_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEFAULT_TIMEOUT = 50_000_000;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_ARMED  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous pin into clk and flags any level change
// (either polarity) of the synchronized level for one cycle.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Only reset clears these, so gating measurement never fabricates an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_q[SYNC_STAGES-1] != prev_q;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period of a square wave and reports it as half-period minus 1,
// locking once two consecutive intervals agree within TOL; flags silence and glitches.
module tone_period_meter
  import buzz_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int TOL         = 1,
  parameter int MIN_HALF    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic             level,
  output logic [WIDTH-1:0] frequency,
  output logic             freq_valid,
  output logic             silent,
  output logic             glitch,
  output logic [1:0]       fsm_state
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] TOL_W    = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_HALF);

  logic             edge_det;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] diff;
  logic             within_tol;
  logic             is_glitch;
  logic             at_limit;
  meter_state_t     state_q;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (pwm_in),
    .level    (level),
    .edge_det (edge_det)
  );

  // Larger-minus-smaller keeps the difference from wrapping.
  always_comb begin
    diff       = (cnt >= cand) ? (cnt - cand) : (cand - cnt);
    within_tol = diff <= TOL_W;
    is_glitch  = cnt < MIN_W;
    at_limit   = cnt == CNT_MAX;
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt        <= '0;
      cand       <= '0;
      frequency  <= '0;
      freq_valid <= 1'b0;
      silent     <= 1'b1;
      glitch     <= 1'b0;
      state_q    <= ST_SILENT;
    end else begin
      glitch <= 1'b0;
      if (edge_det)      cnt <= '0;
      else if (!at_limit) cnt <= cnt + 1'b1;

      if (state_q == ST_SILENT) begin
        if (edge_det) begin
          silent  <= 1'b0;
          state_q <= ST_ARMED;
        end
      end else if (edge_det) begin
        // Glitch rejection outranks the tolerance comparison.
        if (is_glitch) begin
          glitch     <= 1'b1;
          freq_valid <= 1'b0;
          frequency  <= '0;
          state_q    <= ST_ARMED;
        end else begin
          cand <= cnt;
          case (state_q)
            ST_ARMED: state_q <= ST_CHECK;
            ST_CHECK: begin
              if (within_tol) begin
                frequency  <= cnt;
                freq_valid <= 1'b1;
                state_q    <= ST_LOCKED;
              end
            end
            ST_LOCKED: begin
              if (within_tol) begin
                frequency <= cnt;
              end else begin
                frequency  <= '0;
                freq_valid <= 1'b0;
                state_q    <= ST_CHECK;
              end
            end
            default: state_q <= ST_SILENT;
          endcase
        end
      end else if (at_limit) begin
        silent     <= 1'b1;
        freq_valid <= 1'b0;
        frequency  <= '0;
        state_q    <= ST_SILENT;
      end
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: table of square-wave intervals with expected
// outputs, plus hand sequences for glitch, enable gating, silence timeout and reset.
module tb_tone_period_meter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 2000;
  localparam int SETTLE  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             pwm_in;
  logic             level;
  logic [WIDTH-1:0] frequency;
  logic             freq_valid;
  logic             silent;
  logic             glitch;
  logic [1:0]       fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int slack = 0;

  typedef struct {
    int half;
    int n;
    int exp_freq;
    bit exp_valid;
    bit exp_silent;
  } vec_t;

  vec_t vecs[16];

  tone_period_meter #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .TOL(1), .MIN_HALF(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .level      (level),
    .frequency  (frequency),
    .freq_valid (freq_valid),
    .silent     (silent),
    .glitch     (glitch),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pin interval of 'half' clocks measured from the previous toggle.
  task automatic apply_interval(input int half);
    repeat (half - slack) @(negedge clk);
    pwm_in = ~pwm_in;
    slack  = 0;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
    slack = SETTLE;
  endtask

  task automatic check_outputs(input string tag, input int f, input bit v, input bit s);
    check({tag, " frequency"},  frequency,  f);
    check({tag, " freq_valid"}, freq_valid, 32'(v));
    check({tag, " silent"},     silent,     32'(s));
    check({tag, " glitch"},     glitch,     0);
  endtask

  initial begin
    int gcount;
    int found;

    vecs[0]  = '{1000, 1,   0, 1'b0, 1'b0};
    vecs[1]  = '{1000, 1,   0, 1'b0, 1'b0};
    vecs[2]  = '{1000, 1, 999, 1'b1, 1'b0};
    vecs[3]  = '{1000, 3, 999, 1'b1, 1'b0};
    vecs[4]  = '{500,  1,   0, 1'b0, 1'b0};
    vecs[5]  = '{500,  1, 499, 1'b1, 1'b0};
    vecs[6]  = '{500,  2, 499, 1'b1, 1'b0};
    vecs[7]  = '{501,  1, 500, 1'b1, 1'b0};
    vecs[8]  = '{500,  1, 499, 1'b1, 1'b0};
    vecs[9]  = '{502,  1,   0, 1'b0, 1'b0};
    vecs[10] = '{502,  1, 501, 1'b1, 1'b0};
    vecs[11] = '{5,    1,   0, 1'b0, 1'b0};
    vecs[12] = '{5,    1,   4, 1'b1, 1'b0};
    vecs[13] = '{6,    1,   5, 1'b1, 1'b0};
    vecs[14] = '{5,    1,   4, 1'b1, 1'b0};
    vecs[15] = '{6,    1,   5, 1'b1, 1'b0};

    // Clock/reset
    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b1);
    check("reset state", fsm_state, 0);
    reset = 1'b0;
    slack = 0;

    // Table: intervals, lock, retune, jitter, loopback-style short period
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vecs[i].n; k++) apply_interval(vecs[i].half);
      settle();
      check_outputs($sformatf("v%0d", i), vecs[i].exp_freq, vecs[i].exp_valid, vecs[i].exp_silent);
    end

    // Glitch while locked
    apply_interval(100);
    settle();
    apply_interval(100);
    settle();
    check_outputs("pre-glitch", 99, 1'b1, 1'b0);
    repeat (50 - slack) @(negedge clk);
    pwm_in = ~pwm_in;
    @(negedge clk);
    pwm_in = ~pwm_in;
    gcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (glitch) gcount++;
    end
    slack = 6;
    check("glitch pulse count", gcount, 1);
    check("glitch freq_valid", freq_valid, 0);
    check("glitch frequency", frequency, 0);
    check("glitch state", fsm_state, 1);
    apply_interval(100);
    settle();
    check_outputs("relock 1", 0, 1'b0, 1'b0);
    apply_interval(100);
    settle();
    check_outputs("relock 2", 99, 1'b1, 1'b0);

    // Enable gating mid-lock; pin toggles while disabled must not fire on re-enable
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("disabled", 0, 1'b0, 1'b1);
    pwm_in = ~pwm_in;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs("re-enable", 0, 1'b0, 1'b1);
    check("re-enable state", fsm_state, 0);
    slack = 0;
    apply_interval(100);
    settle();
    check_outputs("arm after enable", 0, 1'b0, 1'b0);
    apply_interval(100);
    settle();
    apply_interval(100);
    settle();
    check_outputs("lock after enable", 99, 1'b1, 1'b0);

    // Halt pin while locked: silence declared TIMEOUT clocks after the edge cycle
    apply_interval(100);
    found = 0;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge clk);
      if (silent) begin
        found = c;
        break;
      end
    end
    check("silence delay", found, 2003);
    check("silence frequency", frequency, 0);
    check("silence freq_valid", freq_valid, 0);
    check("silence state", fsm_state, 0);

    // Reset mid-lock
    slack = 0;
    apply_interval(100);
    settle();
    apply_interval(100);
    settle();
    apply_interval(100);
    settle();
    check_outputs("pre-reset lock", 99, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("reset mid-lock", 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("after reset", 0, 1'b0, 1'b1);
    check("after reset state", fsm_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
